// File: rtl/frame_buffer_writer_if.sv
// Handshake bundle between the render engine, the frame buffer memory port
// and the frame_buffer_writer that sits between them.
interface frame_buffer_writer_if #(
  parameter int unsigned HBI     = 32,
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned ADDR_W  = 19
);
  logic [HBI-1:0]     data;
  logic               ready;
  logic               frame_ready;
  logic               send_data;
  logic               start_render;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [PIXEL_W-1:0] mem_wdata;
  logic               mem_ack;

  // Engine and memory side: produce pixel words and acknowledges.
  modport master (
    output data, ready, frame_ready, mem_ack,
    input  send_data, start_render, mem_req, mem_addr, mem_wdata
  );

  // Writer side: consumes pixel words and issues memory writes.
  modport slave (
    input  data, ready, frame_ready, mem_ack,
    output send_data, start_render, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Pulls iteration counts from the render engine, maps each to a colour and
// writes it to sequential frame buffer addresses; reports frame completion.
module frame_buffer_writer #(
  parameter int unsigned X_SIZE       = 640,
  parameter int unsigned Y_SIZE       = 480,
  parameter int unsigned HBI          = 32,
  parameter int unsigned PIXEL_W      = 8,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned MAX_ITER     = 255,
  parameter int unsigned INSIDE_COLOR = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  enable,
  frame_buffer_writer_if.slave  bus,
  output logic                  frame_done,
  output logic                  short_frame_err,
  output logic [18:0]           pixel_count
);

  localparam logic [18:0]        TOTAL    = 19'(X_SIZE * Y_SIZE);
  localparam logic [HBI-1:0]     MAX_IT_W = HBI'(MAX_ITER);
  localparam logic [ADDR_W-1:0]  BASE_W   = ADDR_W'(BASE_ADDR);
  localparam logic [PIXEL_W-1:0] INSIDE_W = PIXEL_W'(INSIDE_COLOR);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2,
    SETTLE    = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               send_data_r, send_data_s;
  logic               start_render_r, start_render_s;
  logic               mem_req_r, mem_req_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
  logic [PIXEL_W-1:0] mem_wdata_r, mem_wdata_s;
  logic               frame_done_r, frame_done_s;
  logic               short_err_r, short_err_s;
  logic [18:0]        count_r, count_s;

  // Points at or beyond MAX_ITER are inside the set; the compare is unsigned.
  function automatic logic [PIXEL_W-1:0] map_colour(input logic [HBI-1:0] iter);
    logic [PIXEL_W-1:0] colour;
    if (iter >= MAX_IT_W) begin
      colour = INSIDE_W;
    end else begin
      colour = iter[PIXEL_W-1:0];
    end
    return colour;
  endfunction

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    state_s        = state_r;
    send_data_s    = 1'b0;
    start_render_s = 1'b0;
    frame_done_s   = 1'b0;
    mem_req_s      = mem_req_r;
    mem_addr_s     = mem_addr_r;
    mem_wdata_s    = mem_wdata_r;
    short_err_s    = short_err_r;
    count_s        = count_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          start_render_s = 1'b1;
          count_s        = 19'd0;
          state_s        = WAIT_DATA;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_DATA: begin
        if (bus.ready) begin
          if (count_r == TOTAL) begin
            // Overrun word: consume it without touching memory.
            send_data_s = 1'b1;
            state_s     = SETTLE;
          end else begin
            mem_req_s   = 1'b1;
            mem_addr_s  = BASE_W + ADDR_W'(count_r);
            mem_wdata_s = map_colour(bus.data);
            state_s     = WRITE;
          end
        end else if (bus.frame_ready) begin
          if (count_r == TOTAL) begin
            frame_done_s = 1'b1;
          end else begin
            short_err_s = 1'b1;
          end
          state_s = IDLE;
        end else begin
          state_s = WAIT_DATA;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          mem_req_s   = 1'b0;
          send_data_s = 1'b1;
          count_s     = count_r + 19'd1;
          state_s     = SETTLE;
        end else begin
          state_s = WRITE;
        end
      end
      SETTLE: begin
        state_s = WAIT_DATA;
      end
      default: begin
        mem_req_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any write in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r        <= IDLE;
      send_data_r    <= 1'b0;
      start_render_r <= 1'b0;
      mem_req_r      <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      frame_done_r   <= 1'b0;
      short_err_r    <= 1'b0;
      count_r        <= 19'd0;
    end else begin
      state_r        <= state_s;
      send_data_r    <= send_data_s;
      start_render_r <= start_render_s;
      mem_req_r      <= mem_req_s;
      mem_addr_r     <= mem_addr_s;
      mem_wdata_r    <= mem_wdata_s;
      frame_done_r   <= frame_done_s;
      short_err_r    <= short_err_s;
      count_r        <= count_s;
    end
  end

  assign bus.send_data    = send_data_r;
  assign bus.start_render = start_render_r;
  assign bus.mem_req      = mem_req_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_wdata    = mem_wdata_r;
  assign frame_done       = frame_done_r;
  assign short_frame_err  = short_err_r;
  assign pixel_count      = count_r;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer on a 4x2 frame, plus a second
// instance with a raised MAX_ITER to exercise the wide colour compare.
module tb_frame_buffer_writer;

  logic        CLK;
  logic        RST_N;
  logic        enable;
  logic        enable2;
  logic        frame_done, frame_done2;
  logic        short_err, short_err2;
  logic [18:0] pixel_count, pixel_count2;

  int n_checks = 0;
  int n_errors = 0;

  frame_buffer_writer_if #(.HBI(32), .PIXEL_W(8), .ADDR_W(19)) bus ();
  frame_buffer_writer_if #(.HBI(32), .PIXEL_W(8), .ADDR_W(19)) bus2 ();

  frame_buffer_writer #(.X_SIZE(4), .Y_SIZE(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .bus(bus),
    .frame_done(frame_done), .short_frame_err(short_err), .pixel_count(pixel_count)
  );

  frame_buffer_writer #(.X_SIZE(4), .Y_SIZE(2), .MAX_ITER(32'h20000)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable2), .bus(bus2),
    .frame_done(frame_done2), .short_frame_err(short_err2), .pixel_count(pixel_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One word through WAIT_DATA -> WRITE -> SETTLE -> WAIT_DATA.
  task automatic feed_pixel(input logic [31:0] d, input int ack_delay,
                            input logic [18:0] exp_addr, input logic [7:0] exp_wdata,
                            input logic [18:0] exp_count);
    bus.ready = 1'b1;
    bus.data  = d;
    tick();
    bus.frame_ready = 1'b0;
    check("req_up",    64'(bus.mem_req),   64'd1);
    check("addr",      64'(bus.mem_addr),  64'(exp_addr));
    check("wdata",     64'(bus.mem_wdata), 64'(exp_wdata));
    check("send_wait", 64'(bus.send_data), 64'd0);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("bp_req",   64'(bus.mem_req),   64'd1);
      check("bp_addr",  64'(bus.mem_addr),  64'(exp_addr));
      check("bp_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
      check("bp_send",  64'(bus.send_data), 64'd0);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.ready   = 1'b0;
    check("send_pulse", 64'(bus.send_data), 64'd1);
    check("req_down",   64'(bus.mem_req),   64'd0);
    check("count",      64'(pixel_count),   64'(exp_count));
    tick();
    check("send_once",  64'(bus.send_data), 64'd0);
  endtask

  logic [31:0] frame_data [8] = '{32'd17, 32'd255, 32'd300, 32'd254,
                                  32'd0, 32'd1, 32'd128, 32'h105};
  logic [7:0]  frame_col  [8] = '{8'd17, 8'd0, 8'd0, 8'd254,
                                  8'd0, 8'd1, 8'd128, 8'd0};
  int          frame_dly  [8] = '{2, 0, 0, 10, 0, 0, 0, 0};

  initial begin
    RST_N = 1'b0;
    enable = 1'b0;
    enable2 = 1'b0;
    bus.data = 32'd0;  bus.ready = 1'b0;  bus.frame_ready = 1'b0;  bus.mem_ack = 1'b0;
    bus2.data = 32'd0; bus2.ready = 1'b0; bus2.frame_ready = 1'b0; bus2.mem_ack = 1'b0;
    #12;
    check("rst_send",  64'(bus.send_data),    64'd0);
    check("rst_start", 64'(bus.start_render), 64'd0);
    check("rst_req",   64'(bus.mem_req),      64'd0);
    check("rst_addr",  64'(bus.mem_addr),     64'd0);
    check("rst_wdata", 64'(bus.mem_wdata),    64'd0);
    check("rst_done",  64'(frame_done),       64'd0);
    check("rst_err",   64'(short_err),        64'd0);
    check("rst_count", 64'(pixel_count),      64'd0);

    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    enable = 1'b1;
    enable2 = 1'b1;
    tick();
    check("start1",     64'(bus.start_render), 64'd1);
    check("start1_cnt", 64'(pixel_count),      64'd0);
    tick();
    check("start1_off", 64'(bus.start_render), 64'd0);

    // Frame 1: full frame with colour map and backpressure.
    for (int p = 0; p < 8; p++) begin
      feed_pixel(frame_data[p], frame_dly[p], 19'(p), frame_col[p], 19'(p + 1));
    end
    check("full_count", 64'(pixel_count), 64'd8);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    check("done_pulse", 64'(frame_done),       64'd1);
    check("done_nostart", 64'(bus.start_render), 64'd0);
    check("done_noerr", 64'(short_err),        64'd0);
    tick();
    check("restart",    64'(bus.start_render), 64'd1);
    check("done_off",   64'(frame_done),       64'd0);
    check("restart_cnt", 64'(pixel_count),     64'd0);
    tick();

    // Frame 2: ready wins over frame_ready, enable drops, frame ends short.
    bus.frame_ready = 1'b1;
    feed_pixel(32'd7, 0, 19'd0, 8'd7, 19'd1);
    check("prio_noerr", 64'(short_err), 64'd0);
    enable = 1'b0;
    for (int p = 1; p < 5; p++) begin
      feed_pixel(32'd40 + 32'(p), 0, 19'(p), 8'd40 + 8'(p), 19'(p + 1));
    end
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    check("short_err",  64'(short_err),  64'd1);
    check("short_nodone", 64'(frame_done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_nostart", 64'(bus.start_render), 64'd0);
      check("err_sticky",   64'(short_err),        64'd1);
    end

    // Frame 3: full frame followed by an overrun word.
    enable = 1'b1;
    tick();
    check("start3", 64'(bus.start_render), 64'd1);
    tick();
    enable = 1'b0;
    for (int p = 0; p < 8; p++) begin
      feed_pixel(32'd3, 0, 19'(p), 8'd3, 19'(p + 1));
    end
    bus.ready = 1'b1;
    bus.data  = 32'd99;
    tick();
    bus.ready = 1'b0;
    check("ovr_send",  64'(bus.send_data), 64'd1);
    check("ovr_noreq", 64'(bus.mem_req),   64'd0);
    check("ovr_count", 64'(pixel_count),   64'd8);
    tick();
    check("ovr_once",  64'(bus.send_data), 64'd0);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    check("ovr_done",  64'(frame_done),    64'd1);
    tick();
    check("ovr_nostart", 64'(bus.start_render), 64'd0);

    // Wide compare: 0x10005 is below the raised MAX_ITER.
    bus2.ready = 1'b1;
    bus2.data  = 32'h0001_0005;
    tick();
    bus2.ready = 1'b0;
    check("wide_req",   64'(bus2.mem_req),   64'd1);
    check("wide_wdata", 64'(bus2.mem_wdata), 64'h05);

    // Reset while a write is outstanding.
    enable = 1'b1;
    tick();
    check("start4", 64'(bus.start_render), 64'd1);
    tick();
    feed_pixel(32'd9, 0, 19'd0, 8'd9, 19'd1);
    bus.ready = 1'b1;
    bus.data  = 32'd11;
    tick();
    check("mid_req",  64'(bus.mem_req),  64'd1);
    check("mid_addr", 64'(bus.mem_addr), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    bus.ready = 1'b0;
    check("arst_req",   64'(bus.mem_req),      64'd0);
    check("arst_count", 64'(pixel_count),      64'd0);
    check("arst_addr",  64'(bus.mem_addr),     64'd0);
    check("arst_wdata", 64'(bus.mem_wdata),    64'd0);
    check("arst_err",   64'(short_err),        64'd0);
    check("arst_send",  64'(bus.send_data),    64'd0);
    check("arst_start", 64'(bus.start_render), 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
    check("start5", 64'(bus.start_render), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
